// File: rtl/math_calculator_fsm_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the keypad calculator core:
//   - operator codes carried on button_op and held as the pending operation
//   - calculator state enumeration
//   - 7-segment constants (minus, blank, digit table), bit order {g,f,e,d,c,b,a}
//   - saturation limit and the saturating narrowing helper
// -----------------------------------------------------------------------------
package calc_pkg;

  // Operator codes (button_op encoding and pending-op register)
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;

  // Calculator sequencing states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTER_A = 3'd1,
    ST_OP_WAIT = 3'd2,
    ST_ENTER_B = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Active-high segment patterns, {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Digit table, element [n] is the pattern for decimal digit n
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  // Largest magnitude a value may hold, in hundredths (99.99)
  localparam logic signed [31:0] SAT_LIMIT = 32'sd9999;

  // Clamp a wide intermediate into the +/-9999 range and narrow to 16 bits
  function automatic logic signed [15:0] saturate(input logic signed [31:0] v);
    logic signed [15:0] r;
    if (v > SAT_LIMIT) begin
      r = 16'sd9999;
    end else if (v < -SAT_LIMIT) begin
      r = -16'sd9999;
    end else begin
      r = v[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/math_calculator_fsm_seven_seg_decoder.sv
// -----------------------------------------------------------------------------
// seven_seg_decoder
// Converts one BCD digit to its active-high 7-segment pattern {g,f,e,d,c,b,a}.
// Codes 10..15 never occur in normal use and are shown blank.
//   digit in  4  BCD digit
//   seg   out 7  segment pattern
// -----------------------------------------------------------------------------
module seven_seg_decoder
  import calc_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // Table lookup with a blank pattern for non-decimal codes
  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_TABLE[digit];
    end else begin
      seg = SEG_BLANK;
    end
  end

endmodule

// File: rtl/math_calculator_fsm.sv
// -----------------------------------------------------------------------------
// math_calculator_fsm
// Keypad-driven fixed-point decimal calculator. Values are signed integers in
// hundredths, saturated to +/-9999 after every operation. Arithmetic chains
// strictly left to right; the displayed value is the last completed result.
//   clk          in   1   rising-edge clock
//   rst          in   1   synchronous active-high reset
//   button       in  10   keypad word, nonzero = one press this cycle
//   clear        out  1   decoded Clear (combinational)
//   button_num   out  4   decoded digit 0..9, 0 when no digit (combinational)
//   button_op    out  3   decoded operator 0 none/1 add/2 sub/3 mul/4 div
//   equal        out  1   decoded Equal (combinational)
//   result_temp  out 16   running accumulator / operand A being typed
//   result       out 16   last completed result
//   sign, tens, units, tenths, hundredths  out 7 each  display of result
// -----------------------------------------------------------------------------
module math_calculator_fsm
  import calc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         button,
  output logic               clear,
  output logic [3:0]         button_num,
  output logic [2:0]         button_op,
  output logic               equal,
  output logic signed [15:0] result_temp,
  output logic signed [15:0] result,
  output logic [6:0]         sign,
  output logic [6:0]         tens,
  output logic [6:0]         units,
  output logic [6:0]         tenths,
  output logic [6:0]         hundredths
);

  // Decoded key
  logic       is_digit_s;
  logic [3:0] digit_s;
  logic [2:0] op_s;
  logic       equal_s;
  logic       clear_s;

  // Sequencing state and datapath registers
  state_e             state_q, state_d;
  logic signed [15:0] acc_q, acc_d;
  logic signed [15:0] operand_q, operand_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic signed [15:0] result_temp_q, result_temp_d;
  logic signed [15:0] result_q, result_d;

  // Operand-building helpers
  logic signed [15:0] digit_ext_s;
  logic signed [15:0] weight_s;
  logic signed [15:0] start_s;
  logic signed [15:0] entry_s;
  logic signed [15:0] alu_s;

  // Display helpers
  logic [15:0] mag_s;
  logic [3:0]  tens_dig_s;
  logic [3:0]  units_dig_s;
  logic [3:0]  tenths_dig_s;
  logic [3:0]  hundredths_dig_s;

  // Single shared ALU: acc op operand with 32-bit intermediates, truncating
  // toward zero, divide-by-zero yields 0, result saturated to +/-9999
  function automatic logic signed [15:0] alu(input logic signed [15:0] a,
                                             input logic signed [15:0] b,
                                             input logic [2:0]         op);
    logic signed [31:0] wa;
    logic signed [31:0] wb;
    logic signed [31:0] r;
    wa = {{16{a[15]}}, a};
    wb = {{16{b[15]}}, b};
    case (op)
      OP_ADD:  r = wa + wb;
      OP_SUB:  r = wa - wb;
      OP_MUL:  r = (wa * wb) / 32'sd100;
      OP_DIV:  r = (wb == 32'sd0) ? 32'sd0 : (wa * 32'sd100) / wb;
      default: r = wa;
    endcase
    return saturate(r);
  endfunction

  // Keypad word decode; Clear and Equal share the 11 prefix so they are
  // mutually exclusive with digits and operators by construction
  always_comb begin
    is_digit_s = 1'b0;
    digit_s    = 4'd0;
    op_s       = OP_NONE;
    equal_s    = 1'b0;
    clear_s    = 1'b0;
    if (button[9] == 1'b0) begin
      is_digit_s = (button[8:0] != 9'd0);
      // Scanning downward lets the lowest set bit win if several are set
      for (int i = 8; i >= 0; i--) begin
        digit_s = button[i] ? 4'(i) : digit_s;
      end
    end else if (button[8] == 1'b0) begin
      if (button == 10'b10_0000_0000) begin
        is_digit_s = 1'b1;
        digit_s    = 4'd9;
      end else if (button[0]) begin
        op_s = OP_ADD;
      end else if (button[1]) begin
        op_s = OP_SUB;
      end else if (button[2]) begin
        op_s = OP_MUL;
      end else if (button[3]) begin
        op_s = OP_DIV;
      end else begin
        op_s = OP_NONE;
      end
    end else begin
      if (button[7]) begin
        clear_s = 1'b1;
      end else begin
        equal_s = 1'b1;
      end
    end
  end

  assign clear      = clear_s;
  assign button_num = digit_s;
  assign button_op  = op_s;
  assign equal      = equal_s;

  // Positional weight of the next digit: units, tenths, hundredths, then none
  always_comb begin
    digit_ext_s = {12'd0, digit_s};
    case (cnt_q)
      2'd0:    weight_s = 16'sd100;
      2'd1:    weight_s = 16'sd10;
      2'd2:    weight_s = 16'sd1;
      default: weight_s = 16'sd0;
    endcase
    start_s = digit_ext_s * 16'sd100;
    entry_s = operand_q + digit_ext_s * weight_s;
    alu_s   = alu(acc_q, operand_q, op_q);
  end

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      acc_q         <= 16'sd0;
      operand_q     <= 16'sd0;
      cnt_q         <= 2'd0;
      op_q          <= OP_NONE;
      result_temp_q <= 16'sd0;
      result_q      <= 16'sd0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      operand_q     <= operand_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      result_temp_q <= result_temp_d;
      result_q      <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clear_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = is_digit_s ? ST_ENTER_A : ST_IDLE;
        end
        ST_ENTER_A: begin
          state_d = (op_s != OP_NONE) ? ST_OP_WAIT : ST_ENTER_A;
        end
        ST_OP_WAIT: begin
          state_d = is_digit_s ? ST_ENTER_B : ST_OP_WAIT;
        end
        ST_ENTER_B: begin
          if (op_s != OP_NONE) begin
            state_d = ST_OP_WAIT;
          end else if (equal_s) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ENTER_B;
          end
        end
        ST_DONE: begin
          if (is_digit_s) begin
            state_d = ST_ENTER_A;
          end else if (op_s != OP_NONE) begin
            state_d = ST_OP_WAIT;
          end else begin
            state_d = ST_DONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath updates driven by the current state and the decoded key
  always_comb begin
    acc_d         = acc_q;
    operand_d     = operand_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    result_temp_d = result_temp_q;
    result_d      = result_q;
    if (clear_s) begin
      acc_d         = 16'sd0;
      operand_d     = 16'sd0;
      cnt_d         = 2'd0;
      op_d          = OP_NONE;
      result_temp_d = 16'sd0;
      result_d      = 16'sd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_digit_s) begin
            acc_d         = 16'sd0;
            operand_d     = start_s;
            cnt_d         = 2'd1;
            result_temp_d = start_s;
          end else begin
            acc_d = acc_q;
          end
        end
        ST_ENTER_A: begin
          // result_temp follows operand A while it is typed
          if (is_digit_s) begin
            operand_d     = entry_s;
            cnt_d         = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
            result_temp_d = entry_s;
          end else if (op_s != OP_NONE) begin
            acc_d         = operand_q;
            op_d          = op_s;
            operand_d     = 16'sd0;
            cnt_d         = 2'd0;
            result_temp_d = operand_q;
          end else begin
            acc_d = acc_q;
          end
        end
        ST_OP_WAIT: begin
          if (is_digit_s) begin
            operand_d = start_s;
            cnt_d     = 2'd1;
          end else if (op_s != OP_NONE) begin
            op_d = op_s;
          end else begin
            acc_d = acc_q;
          end
        end
        ST_ENTER_B: begin
          if (is_digit_s) begin
            operand_d = entry_s;
            cnt_d     = (cnt_q == 2'd3) ? 2'd3 : cnt_q + 2'd1;
          end else if (op_s != OP_NONE) begin
            acc_d         = alu_s;
            result_temp_d = alu_s;
            op_d          = op_s;
            operand_d     = 16'sd0;
            cnt_d         = 2'd0;
          end else if (equal_s) begin
            acc_d         = alu_s;
            result_temp_d = alu_s;
            result_d      = alu_s;
            operand_d     = 16'sd0;
            cnt_d         = 2'd0;
          end else begin
            acc_d = acc_q;
          end
        end
        ST_DONE: begin
          // A digit starts over; an operator chains on the last result
          if (is_digit_s) begin
            acc_d         = 16'sd0;
            operand_d     = start_s;
            cnt_d         = 2'd1;
            result_temp_d = start_s;
          end else if (op_s != OP_NONE) begin
            acc_d         = result_q;
            result_temp_d = result_q;
            op_d          = op_s;
          end else begin
            acc_d = acc_q;
          end
        end
        default: begin
          acc_d = acc_q;
        end
      endcase
    end
  end

  assign result_temp = result_temp_q;
  assign result      = result_q;

  // Split |result| into four decimal digits (magnitude never exceeds 9999)
  always_comb begin
    mag_s            = result_q[15] ? 16'(-result_q) : 16'(result_q);
    tens_dig_s       = 4'(mag_s / 16'd1000);
    units_dig_s      = 4'((mag_s / 16'd100) % 16'd10);
    tenths_dig_s     = 4'((mag_s / 16'd10) % 16'd10);
    hundredths_dig_s = 4'(mag_s % 16'd10);
    sign             = result_q[15] ? SEG_MINUS : SEG_BLANK;
  end

  seven_seg_decoder u_seg_tens       (.digit(tens_dig_s),       .seg(tens));
  seven_seg_decoder u_seg_units      (.digit(units_dig_s),      .seg(units));
  seven_seg_decoder u_seg_tenths     (.digit(tenths_dig_s),     .seg(tenths));
  seven_seg_decoder u_seg_hundredths (.digit(hundredths_dig_s), .seg(hundredths));

endmodule

// File: tb/tb_math_calculator_fsm.sv
// -----------------------------------------------------------------------------
// tb_math_calculator_fsm
// Directed key sequences with a calculator model: a digit list per operand,
// an accumulator, a pending operator and "chaining"/"finished" flags. A
// negedge process compares the registered outputs and display against the
// model every cycle; each key press also checks the combinational decode.
// Literal expectations after each sequence pin the model itself.
// -----------------------------------------------------------------------------
module tb_math_calculator_fsm;

  logic               clk;
  logic               rst;
  logic [9:0]         button;
  logic               clear;
  logic [3:0]         button_num;
  logic [2:0]         button_op;
  logic               equal;
  logic signed [15:0] result_temp;
  logic signed [15:0] result;
  logic [6:0]         sign, tens, units, tenths, hundredths;

  math_calculator_fsm dut (
    .clk(clk), .rst(rst), .button(button),
    .clear(clear), .button_num(button_num), .button_op(button_op), .equal(equal),
    .result_temp(result_temp), .result(result),
    .sign(sign), .tens(tens), .units(units), .tenths(tenths), .hundredths(hundredths)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Calculator model
  int m_acc = 0, m_res = 0, m_rt = 0, m_pend = 0;
  int digs[$];
  bit m_chain = 1'b0, m_fin = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input longint v);
    if (v > 9999) return 9999;
    if (v < -9999) return -9999;
    return int'(v);
  endfunction

  function automatic int calc(input int a, input int b, input int op);
    longint la = a;
    longint lb = b;
    case (op)
      1: return sat(la + lb);
      2: return sat(la - lb);
      3: return sat((la * lb) / 100);
      4: return (lb == 0) ? 0 : sat((la * 100) / lb);
      default: return a;
    endcase
  endfunction

  function automatic int entry_val();
    int w[3] = '{100, 10, 1};
    int v = 0;
    foreach (digs[i]) v += digs[i] * w[i];
    return v;
  endfunction

  function automatic int exp_seg(input int d);
    case (d)
      0: return 7'b0111111;  1: return 7'b0000110;
      2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111;
      default: return 0;
    endcase
  endfunction

  task automatic m_clear();
    m_acc = 0; m_res = 0; m_rt = 0; m_pend = 0;
    digs.delete();
    m_chain = 1'b0; m_fin = 1'b0;
  endtask

  task automatic m_key(input byte c);
    int o;
    o = (c == "+") ? 1 : (c == "-") ? 2 : (c == "*") ? 3 : (c == "/") ? 4 : 0;
    if (c >= "0" && c <= "9") begin
      if (m_fin) begin
        m_fin = 1'b0; m_chain = 1'b0; m_acc = 0; digs.delete();
      end
      if (digs.size() < 3) digs.push_back(int'(c) - 48);
      if (!m_chain) m_rt = entry_val();
    end else if (o != 0) begin
      if (digs.size() > 0) begin
        m_acc = m_chain ? calc(m_acc, entry_val(), m_pend) : entry_val();
        m_rt = m_acc;
        digs.delete();
        m_chain = 1'b1;
        m_pend = o;
      end else if (m_fin) begin
        m_acc = m_res; m_fin = 1'b0; m_chain = 1'b1; m_pend = o;
      end else if (m_chain) begin
        m_pend = o;
      end
    end else if (c == "=") begin
      if (m_chain && digs.size() > 0) begin
        m_acc = calc(m_acc, entry_val(), m_pend);
        m_res = m_acc; m_rt = m_acc;
        digs.delete();
        m_chain = 1'b0; m_fin = 1'b1;
      end
    end else if (c == "C") begin
      m_clear();
    end
  endtask

  // Drive one key for exactly one cycle, check its decode, then advance model
  task automatic key(input byte c);
    logic [9:0] code;
    int en, eo, ee, ec, o;
    code = 10'd0; en = 0; eo = 0; ee = 0; ec = 0;
    o = (c == "+") ? 1 : (c == "-") ? 2 : (c == "*") ? 3 : (c == "/") ? 4 : 0;
    if (c >= "0" && c <= "9") begin
      en = int'(c) - 48;
      code = (en == 9) ? 10'b10_0000_0000 : (10'd1 << en);
    end else if (o != 0) begin
      eo = o;
      code = {2'b10, 4'b0000, 4'(4'b0001 << (o - 1))};
    end else if (c == "=") begin
      ee = 1; code = 10'b11_0000_0000;
    end else if (c == "C") begin
      ec = 1; code = 10'b11_1000_0000;
    end else begin
      code = 10'b10_0001_0000;  // unassigned word: decodes to nothing
    end
    @(negedge clk);
    button = code;
    #1;
    chk("dec_num", int'(button_num), en);
    chk("dec_op", int'(button_op), eo);
    chk("dec_equal", int'(equal), ee);
    chk("dec_clear", int'(clear), ec);
    @(posedge clk);
    m_key(c);
  endtask

  task automatic keys(input string s);
    for (int i = 0; i < s.len(); i++) key(s[i]);
  endtask

  task automatic idle();
    @(negedge clk);
    button = 10'd0;
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    button = 10'd0;
    @(posedge clk);
    m_clear();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Per-cycle comparison of registered outputs and display against the model
  always @(negedge clk) begin
    if (chk_en) begin
      int mag;
      mag = (m_res < 0) ? -m_res : m_res;
      chk("result_temp", int'(result_temp), m_rt);
      chk("result", int'(result), m_res);
      chk("sign", int'(sign), (m_res < 0) ? 7'b1000000 : 7'b0000000);
      chk("tens", int'(tens), exp_seg(mag / 1000));
      chk("units", int'(units), exp_seg((mag / 100) % 10));
      chk("tenths", int'(tenths), exp_seg((mag / 10) % 10));
      chk("hundredths", int'(hundredths), exp_seg(mag % 10));
    end
  end

  initial begin
    rst = 1'b1;
    button = 10'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_result", int'(result), 0);
    chk("rst_result_temp", int'(result_temp), 0);
    chk("rst_sign", int'(sign), 0);
    chk("rst_tens", int'(tens), 7'b0111111);
    chk("rst_hundredths", int'(hundredths), 7'b0111111);
    chk_en = 1'b1;

    keys("525-705="); idle();
    chk("lit_sub", int'(result), -180);
    chk("lit_sub_sign", int'(sign), 7'b1000000);
    chk("lit_sub_units", int'(units), 7'b0000110);
    chk("lit_sub_tenths", int'(tenths), 7'b1111111);
    keys("/200="); idle();
    chk("lit_div_neg", int'(result), -90);

    keys("C525+325="); idle();
    chk("lit_add", int'(result), 850);
    chk("lit_add_tens", int'(tens), 7'b0111111);
    chk("lit_add_units", int'(units), 7'b1111111);
    chk("lit_add_tenths", int'(tenths), 7'b1101101);
    chk("lit_add_hund", int'(hundredths), 7'b0111111);

    keys("500-325+"); idle();
    chk("lit_chain_temp", int'(result_temp), 175);
    keys("225="); idle();
    chk("lit_chain", int'(result), 400);

    keys("600/300="); idle();
    chk("lit_newcalc", int'(result), 200);
    keys("*800="); idle();
    chk("lit_mul", int'(result), 1600);
    chk("lit_mul_tens", int'(tens), 7'b0000110);
    chk("lit_mul_units", int'(units), 7'b1111101);

    keys("C999*999="); idle();
    chk("lit_mul_big", int'(result), 9980);
    keys("*999="); idle();
    chk("lit_sat_pos", int'(result), 9999);
    keys("1-999="); idle();
    chk("lit_neg", int'(result), -899);
    keys("*999="); idle();
    chk("lit_trunc_zero", int'(result), -8981);
    keys("*200="); idle();
    chk("lit_sat_neg", int'(result), -9999);

    keys("100/0="); idle();
    chk("lit_div0", int'(result), 0);

    keys("525+3C"); idle();
    chk("lit_clear_res", int'(result), 0);
    chk("lit_clear_temp", int'(result_temp), 0);
    keys("100+100="); idle();
    chk("lit_after_clear", int'(result), 200);

    keys("400+-100="); idle();
    chk("lit_op_replace", int'(result), 300);
    keys("2=X+1234="); idle();
    chk("lit_extra_digits", int'(result), 323);

    keys("3+4"); do_rst();
    #1;
    chk("lit_midrst_res", int'(result), 0);
    chk("lit_midrst_temp", int'(result_temp), 0);
    keys("25+5="); idle();
    chk("lit_partial", int'(result), 750);
    keys("8*9="); idle();
    chk("lit_digit89", int'(result), 7200);

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
